rep_sequencer: RTL and testbench

Sequencer between the register-read/address-generation stage and memory for REP-prefixed string instructions. It captures the REP count (ECX value) and the two generated memory addresses, then issues one output beat per iteration, stepping both addresses by the operand size in the direction selected by DF. While it iterates, it holds the register-read stage. Non-REP instructions pass through with one cycle of latency.

---
 rtl/rep_sequencer.sv | 132 +++++++++++++
 tb/tb_rep_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rep_sequencer.sv
// Sequences REP string instructions into one memory beat per iteration; non-REP instructions pass straight through.
// Latency: 1 cycle from acceptance to the first beat. REP beats follow back-to-back, one per cycle.
// Backpressure: ds_stall freezes the output beat and all state. stall_up holds the register-read stage during RUN or while frozen.
module rep_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  valid_in,
  input  logic                  rep,
  input  logic [CNT_WIDTH-1:0]  rep_num,
  input  logic [1:0]            opsize,
  input  logic                  df,
  input  logic [ADDR_WIDTH-1:0] addr1_in,
  input  logic [ADDR_WIDTH-1:0] addr2_in,
  input  logic                  ds_stall,
  input  logic                  flush,
  output logic                  valid_out,
  output logic [ADDR_WIDTH-1:0] addr1_out,
  output logic [ADDR_WIDTH-1:0] addr2_out,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic                  last_out,
  output logic                  nop_out,
  output logic                  stall_up,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] ptr1;
  logic [ADDR_WIDTH-1:0] ptr2;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  dir;

  logic                  load_en;
  logic [ADDR_WIDTH-1:0] in_stride;
  logic                  start_run;
  logic                  run_last;

  // Address step with natural modulo-2^ADDR_WIDTH wrap in both directions.
  function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [ADDR_WIDTH-1:0] s,
                                                 input logic              d);
    return d ? (a - s) : (a + s);
  endfunction

  // The output register may be reloaded when it is empty or being consumed.
  assign load_en   = !valid_out || !ds_stall;
  assign in_stride = ADDR_WIDTH'(1) << opsize;
  // Only counts above one need the RUN state; 0 and 1 complete with a single beat.
  assign start_run = (state == IDLE) && valid_in && rep && (rep_num > CNT_WIDTH'(1));
  assign run_last  = (state == RUN) && (cnt == CNT_WIDTH'(1));

  assign busy     = (state == RUN);
  assign stall_up = (state == RUN) || !load_en;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: flush aborts unconditionally, otherwise advance only when the output can load.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (load_en) begin
      case (state)
        IDLE:    if (start_run) state_nxt = RUN;
        RUN:     if (run_last)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register and iteration datapath.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_out <= 1'b0;
      addr1_out <= '0;
      addr2_out <= '0;
      count_out <= '0;
      last_out  <= 1'b0;
      nop_out   <= 1'b0;
      cnt       <= '0;
      ptr1      <= '0;
      ptr2      <= '0;
      stride    <= '0;
      dir       <= 1'b0;
    end else if (flush) begin
      // Drop the beat; the remaining OR fields keep their stale contents.
      valid_out <= 1'b0;
      cnt       <= '0;
      ptr1      <= '0;
      ptr2      <= '0;
    end else if (load_en) begin
      if (state == IDLE) begin
        valid_out <= valid_in;
        if (valid_in) begin
          addr1_out <= addr1_in;
          addr2_out <= addr2_in;
          count_out <= rep ? rep_num : '0;
          last_out  <= !start_run;
          nop_out   <= rep && (rep_num == '0);
        end
        if (start_run) begin
          cnt    <= rep_num - CNT_WIDTH'(1);
          ptr1   <= step(addr1_in, in_stride, df);
          ptr2   <= step(addr2_in, in_stride, df);
          stride <= in_stride;
          dir    <= df;
        end
      end else begin
        valid_out <= 1'b1;
        addr1_out <= ptr1;
        addr2_out <= ptr2;
        count_out <= cnt;
        last_out  <= run_last;
        nop_out   <= 1'b0;
        cnt       <= cnt - CNT_WIDTH'(1);
        ptr1      <= step(ptr1, stride, dir);
        ptr2      <= step(ptr2, stride, dir);
      end
    end
  end

endmodule

// File: tb/tb_rep_sequencer.sv
// Directed bench for rep_sequencer: non-REP pass-through, REP sequencing, wrap, stall, nop, flush and reset abort.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Every comparison goes through check_eq, which keeps the compared/mismatched counters.
module tb_rep_sequencer;

  logic        clk;
  logic        clr;
  logic        valid_in;
  logic        rep;
  logic [31:0] rep_num;
  logic [1:0]  opsize;
  logic        df;
  logic [31:0] addr1_in;
  logic [31:0] addr2_in;
  logic        ds_stall;
  logic        flush;
  logic        valid_out;
  logic [31:0] addr1_out;
  logic [31:0] addr2_out;
  logic [31:0] count_out;
  logic        last_out;
  logic        nop_out;
  logic        stall_up;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;

  rep_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .valid_in  (valid_in),
    .rep       (rep),
    .rep_num   (rep_num),
    .opsize    (opsize),
    .df        (df),
    .addr1_in  (addr1_in),
    .addr2_in  (addr2_in),
    .ds_stall  (ds_stall),
    .flush     (flush),
    .valid_out (valid_out),
    .addr1_out (addr1_out),
    .addr2_out (addr2_out),
    .count_out (count_out),
    .last_out  (last_out),
    .nop_out   (nop_out),
    .stall_up  (stall_up),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count beats actually taken by downstream.
  always @(posedge clk) if (valid_out && !ds_stall) beats++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic r, input logic [31:0] n, input logic [1:0] sz,
                         input logic d, input logic [31:0] a1, input logic [31:0] a2);
    valid_in = 1'b1;
    rep      = r;
    rep_num  = n;
    opsize   = sz;
    df       = d;
    addr1_in = a1;
    addr2_in = a2;
  endtask

  task automatic beat(input string tag, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] c, input logic l, input logic nop);
    check_eq({tag, ".valid"}, valid_out, 1);
    check_eq({tag, ".addr1"}, addr1_out, a1);
    check_eq({tag, ".addr2"}, addr2_out, a2);
    check_eq({tag, ".count"}, count_out, c);
    check_eq({tag, ".last"},  last_out,  l);
    check_eq({tag, ".nop"},   nop_out,   nop);
  endtask

  initial begin
    clr = 1'b0; valid_in = 1'b0; rep = 1'b0; rep_num = '0; opsize = '0; df = 1'b0;
    addr1_in = '0; addr2_in = '0; ds_stall = 1'b0; flush = 1'b0;
    #12;
    check_eq("rst.valid", valid_out, 0);
    check_eq("rst.busy",  busy,      0);
    check_eq("rst.stall", stall_up,  0);
    check_eq("rst.count", count_out, 0);
    check_eq("rst.last",  last_out,  0);
    check_eq("rst.nop",   nop_out,   0);
    clr = 1'b1;
    tick();

    // Non-REP pass-through.
    present(1'b0, 32'd7, 2'd0, 1'b0, 32'h1000, 32'h2000);
    #1 check_eq("nr.stall0", stall_up, 0);
    tick();
    valid_in = 1'b0;
    beat("nr", 32'h1000, 32'h2000, 0, 1, 0);
    #1 check_eq("nr.stall1", stall_up, 0);
    tick();
    check_eq("nr.idle", valid_out, 0);

    // REP 3, dword, ascending.
    present(1'b1, 32'd3, 2'd2, 1'b0, 32'h100, 32'h200);
    #1 check_eq("r3.stall0", stall_up, 0);
    tick();
    valid_in = 1'b0;
    beat("r3.b1", 32'h100, 32'h200, 3, 0, 0);
    #1 check_eq("r3.stall1", stall_up, 1);
    tick();
    beat("r3.b2", 32'h104, 32'h204, 2, 0, 0);
    check_eq("r3.stall2", stall_up, 1);
    tick();
    beat("r3.b3", 32'h108, 32'h208, 1, 1, 0);
    check_eq("r3.stall3", stall_up, 0);
    check_eq("r3.busy3",  busy,     0);
    tick();
    check_eq("r3.idle", valid_out, 0);

    // REP 2, byte, descending across zero.
    present(1'b1, 32'd2, 2'd0, 1'b1, 32'h0, 32'h10);
    tick();
    valid_in = 1'b0;
    beat("wr.b1", 32'h0, 32'h10, 2, 0, 0);
    tick();
    beat("wr.b2", 32'hFFFF_FFFF, 32'hF, 1, 1, 0);
    tick();

    // REP 4, word, with downstream stall on beat 2.
    present(1'b1, 32'd4, 2'd1, 1'b0, 32'h40, 32'h80);
    beats = 0;
    tick();
    valid_in = 1'b0;
    beat("st.b1", 32'h40, 32'h80, 4, 0, 0);
    tick();
    beat("st.b2", 32'h42, 32'h82, 3, 0, 0);
    ds_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("st.hold", 32'h42, 32'h82, 3, 0, 0);
      check_eq("st.stall", stall_up, 1);
    end
    ds_stall = 1'b0;
    tick();
    beat("st.b3", 32'h44, 32'h84, 2, 0, 0);
    tick();
    beat("st.b4", 32'h46, 32'h86, 1, 1, 0);
    tick();
    check_eq("st.idle",  valid_out, 0);
    check_eq("st.beats", beats,     4);

    // REP 1, REP 0 and a following non-REP back-to-back.
    present(1'b1, 32'd1, 2'd3, 1'b0, 32'h500, 32'h600);
    tick();
    beat("r1", 32'h500, 32'h600, 1, 1, 0);
    check_eq("r1.busy", busy, 0);
    present(1'b1, 32'd0, 2'd3, 1'b0, 32'h700, 32'h800);
    #1 check_eq("r1.stall", stall_up, 0);
    tick();
    beat("r0", 32'h700, 32'h800, 0, 1, 1);
    present(1'b0, 32'd9, 2'd0, 1'b0, 32'h3000, 32'h4000);
    #1 check_eq("r0.stall", stall_up, 0);
    tick();
    valid_in = 1'b0;
    beat("r0.next", 32'h3000, 32'h4000, 0, 1, 0);
    tick();

    // Flush on beat 2 of REP 5, with ds_stall also asserted.
    present(1'b1, 32'd5, 2'd2, 1'b0, 32'h900, 32'hA00);
    tick();
    valid_in = 1'b0;
    tick();
    beat("fl.b2", 32'h904, 32'hA04, 4, 0, 0);
    flush = 1'b1;
    ds_stall = 1'b1;
    tick();
    flush = 1'b0;
    ds_stall = 1'b0;
    check_eq("fl.valid", valid_out, 0);
    check_eq("fl.busy",  busy,      0);
    tick();
    check_eq("fl.after", valid_out, 0);

    // Asynchronous reset during RUN.
    present(1'b1, 32'd3, 2'd0, 1'b0, 32'h20, 32'h30);
    tick();
    valid_in = 1'b0;
    check_eq("cr.busy0", busy, 1);
    clr = 1'b0;
    #1;
    check_eq("cr.valid", valid_out, 0);
    check_eq("cr.busy",  busy,      0);
    check_eq("cr.count", count_out, 0);
    check_eq("cr.stall", stall_up,  0);
    #2 clr = 1'b1;
    tick();
    check_eq("cr.after1", valid_out, 0);
    tick();
    check_eq("cr.after2", valid_out, 0);
    check_eq("cr.busy2",  busy,      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
